// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses PLL reset, waits for and qualifies lock, then releases
// the downstream reset. Optional lock-loss event counter enabled by macro LOCK_LOSS_CNT_EN.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       locked_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned MaxA   = (PLL_RST_CYC > STABLE_CYC) ? PLL_RST_CYC : STABLE_CYC;
  localparam int unsigned MaxCyc = (MaxA > LOCK_TIMEOUT_CYC) ? MaxA : LOCK_TIMEOUT_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] RstLast    = CntW'(PLL_RST_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYC - 1);
  localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StResetPll,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [CntW-1:0]        r_cnt;
  logic [3:0]             r_retry;
  logic [3:0]             w_retry_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_sync;
  logic                   r_pll_rst;
  logic                   r_run;
  logic                   r_fault;

  assign w_lock_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_retry_d = r_retry;
    unique case (r_state)
      StResetPll: begin
        if (r_cnt == RstLast) w_state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock observed on the timeout cycle takes priority over the timeout.
        if (w_lock_sync) begin
          w_state_d = StStable;
        end else if (r_cnt == TimeoutLast) begin
          if (r_retry == MaxRetry) begin
            w_state_d = StFault;
          end else begin
            w_retry_d = r_retry + 4'd1;
            w_state_d = StResetPll;
          end
        end
      end
      StStable: begin
        if (!w_lock_sync) begin
          w_state_d = StWaitLock;
        end else if (r_cnt == StableLast) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (!w_lock_sync) w_state_d = StResetPll;
      end
      StFault: begin
        if (restart_i) begin
          w_retry_d = '0;
          w_state_d = StResetPll;
        end
      end
      default: w_state_d = StResetPll;
    endcase
    if (w_state_d == StRun) w_retry_d = '0;
  end

  // Outputs are registered from the next state so they line up exactly with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StResetPll;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_pll_rst <= 1'b1;
      r_run     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_retry   <= w_retry_d;
      r_pll_rst <= (w_state_d == StResetPll) || (w_state_d == StFault);
      r_run     <= (w_state_d == StRun);
      r_fault   <= (w_state_d == StFault);
      if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == StResetPll) || (r_state == StWaitLock) ||
                   (r_state == StStable)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loss_cnt <= '0;
    end else if ((r_state == StRun) && (w_state_d == StResetPll) && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt_o = r_loss_cnt;
`else
  assign lock_loss_cnt_o = '0;
`endif

  assign pll_rst_o   = r_pll_rst;
  assign sys_rst_n_o = r_run;
  assign locked_o    = r_run;
  assign fault_o     = r_fault;
  assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued with the stimulus and
// popped as the measured DUT responses arrive.
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LTC = 20;
  localparam int SC  = 8;
  localparam int MR  = 2;
  localparam int SS  = 2;
  localparam int LockToRun = SS + SC + 1;
`ifdef LOCK_LOSS_CNT_EN
  localparam int LlcOne = 1;
  localparam int LlcSat = 255;
`else
  localparam int LlcOne = 0;
  localparam int LlcSat = 0;
`endif

  localparam int OPll = 0;
  localparam int OSys = 1;
  localparam int OFault = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       locked_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  pll_lock_supervisor #(
    .PLL_RST_CYC     (PRC),
    .LOCK_TIMEOUT_CYC(LTC),
    .STABLE_CYC      (SC),
    .MAX_RETRY       (MR),
    .SYNC_STAGES     (SS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_lock_i     (pll_lock_i),
    .restart_i      (restart_i),
    .pll_rst_o      (pll_rst_o),
    .sys_rst_n_o    (sys_rst_n_o),
    .locked_o       (locked_o),
    .fault_o        (fault_o),
    .retry_cnt_o    (retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   rise_cnt = 0;

  always @(posedge sys_rst_n_o) rise_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic int get_out(input int sel);
    case (sel)
      OPll:    return int'(pll_rst_o);
      OSys:    return int'(sys_rst_n_o);
      default: return int'(fault_o);
    endcase
  endfunction

  // Negedges waited until the output reaches val; -1 if the budget expires.
  task automatic wait_out(input int sel, input int val, input int budget, output int n);
    n = 0;
    while (get_out(sel) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (get_out(sel) != val) n = -1;
  endtask

  task automatic check_reset_vals(input string pfx);
    push({pfx, "_pll_rst"}, 1);
    push({pfx, "_sys_rst_n"}, 0);
    push({pfx, "_locked"}, 0);
    push({pfx, "_fault"}, 0);
    push({pfx, "_retry"}, 0);
    push({pfx, "_llc"}, 0);
    pop_check(int'(pll_rst_o));
    pop_check(int'(sys_rst_n_o));
    pop_check(int'(locked_o));
    pop_check(int'(fault_o));
    pop_check(int'(retry_cnt_o));
    pop_check(int'(lock_loss_cnt_o));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int to;
    int r;

    rst_n      = 1'b0;
    pll_lock_i = 1'b0;
    restart_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    // Normal acquisition.
    rst_n = 1'b1;
    push("s1_rst_pulse", PRC);
    wait_out(OPll, 0, 50, n);
    pop_check(n);
    repeat (6) @(negedge clk);
    pll_lock_i = 1'b1;
    push("s1_lock_to_run", LockToRun);
    push("s1_locked", 1);
    push("s1_retry", 0);
    push("s1_pll_rst", 0);
    wait_out(OSys, 1, 100, n);
    pop_check(n);
    pop_check(int'(locked_o));
    pop_check(int'(retry_cnt_o));
    pop_check(int'(pll_rst_o));

    // Lock loss in RUN.
    pll_lock_i = 1'b0;
    push("s5_fall_delay", 3);
    push("s5_pll_rst", 1);
    push("s5_pulse", PRC);
    push("s5_llc", LlcOne);
    push("s5_retry", 0);
    wait_out(OSys, 0, 20, n);
    pop_check(n);
    pop_check(int'(pll_rst_o));
    wait_out(OPll, 0, 20, n);
    pop_check(n);
    pop_check(int'(lock_loss_cnt_o));
    pop_check(int'(retry_cnt_o));

    push("s5_llc_sat", LlcSat);
    push("s5_loop_timeouts", 0);
    to = 0;
    for (int i = 0; i < 299; i++) begin
      pll_lock_i = 1'b1;
      wait_out(OSys, 1, 60, n);
      if (n < 0) to++;
      pll_lock_i = 1'b0;
      wait_out(OSys, 0, 20, n);
      if (n < 0) to++;
      if (to != 0) break;
    end
    pop_check(int'(lock_loss_cnt_o));
    pop_check(to);

    // Asynchronous reset mid-RUN.
    pll_lock_i = 1'b1;
    push("s6r_reach_run", 1);
    wait_out(OSys, 1, 60, n);
    pop_check(int'(n > 0));
    r = rise_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("s6r");
    pll_lock_i = 1'b0;
    repeat (3) @(negedge clk);
    push("s6r_no_glitch", r);
    pop_check(rise_cnt);

    // Lock never arrives: retries then FAULT.
    rst_n = 1'b1;
    for (int k = 0; k <= MR; k++) begin
      push("s2_pulse", PRC);
      push("s2_retry", k);
      push("s2_wait", LTC);
      wait_out(OPll, 0, 50, n);
      pop_check(n);
      pop_check(int'(retry_cnt_o));
      wait_out(OPll, 1, 50, n);
      pop_check(n);
    end
    push("s2_fault", 1);
    push("s2_fault_retry", MR);
    push("s2_fault_sys", 0);
    push("s2_hold", 100);
    pop_check(int'(fault_o));
    pop_check(int'(retry_cnt_o));
    pop_check(int'(sys_rst_n_o));
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (fault_o && pll_rst_o && !sys_rst_n_o) cnt++;
    end
    pop_check(cnt);

    // Restart from FAULT.
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    push("s3_fault_clr", 0);
    push("s3_retry", 0);
    push("s3_pll_rst", 1);
    push("s3_pulse", PRC);
    pop_check(int'(fault_o));
    pop_check(int'(retry_cnt_o));
    pop_check(int'(pll_rst_o));
    wait_out(OPll, 0, 50, n);
    pop_check(n);
    pll_lock_i = 1'b1;
    push("s3_lock_to_run", LockToRun);
    wait_out(OSys, 1, 100, n);
    pop_check(n);
    restart_i = 1'b1;
    repeat (5) @(negedge clk);
    restart_i = 1'b0;
    push("s3_restart_ignored", 1);
    pop_check(int'(locked_o && !pll_rst_o && !fault_o));

    // Short lock drop during STABLE restarts qualification.
    pll_lock_i = 1'b0;
    wait_out(OSys, 0, 20, n);
    push("s4_pulse", PRC);
    wait_out(OPll, 0, 20, n);
    pop_check(n);
    pll_lock_i = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (sys_rst_n_o) cnt++;
    end
    pll_lock_i = 1'b0;
    @(negedge clk);
    pll_lock_i = 1'b1;
    push("s4_early_run", 0);
    push("s4_restable", LockToRun);
    pop_check(cnt);
    wait_out(OSys, 1, 60, n);
    pop_check(n);

    // Asynchronous reset mid-STABLE.
    pll_lock_i = 1'b0;
    wait_out(OSys, 0, 20, n);
    pll_lock_i = 1'b1;
    wait_out(OPll, 0, 20, n);
    repeat (3) @(negedge clk);
    push("s6s_pre_sys", 0);
    push("s6s_pre_pll", 0);
    pop_check(int'(sys_rst_n_o));
    pop_check(int'(pll_rst_o));
    r = rise_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("s6s");
    repeat (3) @(negedge clk);
    push("s6s_no_glitch", r);
    pop_check(rise_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
